// File: rtl/dac_out_fmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_out_fmt_pkg
// Description : Shared types and helpers for the DAC output formatter and
//               its lock-qualified reset sequencer.
//               - seq_state_e   : sequencer state encoding
//               - clog2()       : counter width helper
//               - HOLD_IDLE_BIT : bit value loaded into forced-idle hold regs
// Revision    : 1.0 - initial release
// ============================================================================
package dac_out_fmt_pkg;

  typedef enum logic [1:0] {
    SEQ_WAIT_LOCK = 2'd0,
    SEQ_COUNT     = 2'd1,
    SEQ_RUN       = 2'd2
  } seq_state_e;

  // Hold registers are cleared to this bit; the pin-level idle code is this
  // value passed through the output map (all-ones when inverting).
  localparam logic HOLD_IDLE_BIT = 1'b0;

  // Minimum width able to hold values 0 .. value-1 (at least 1 bit).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_lock_seq.sv
`default_nettype none
// ============================================================================
// Module      : dac_lock_seq
// Description : Lock-qualified reset sequencer. Releases the converter reset
//               once the PLL has been locked for LOCK_CYCLES consecutive
//               cycles; any lock loss re-asserts reset on the next edge.
// Ports       : clk_i     - clock
//               rstn_i    - asynchronous active-low reset
//               locked_i  - PLL lock, synchronous to clk_i
//               rst_o     - converter reset, active high (registered)
//               ready_o   - high while in RUN (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module dac_lock_seq
  import dac_out_fmt_pkg::*;
#(
  parameter int LOCK_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic locked_i,
  output logic rst_o,
  output logic ready_o
);

  localparam int CNT_W = clog2(LOCK_CYCLES);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_q, rst_d;
  logic             ready_q, ready_d;

  // The cycle that leaves WAIT_LOCK counts as the first locked cycle (cnt=0),
  // so RUN is entered after exactly LOCK_CYCLES consecutive locked cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SEQ_WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_i) state_d = SEQ_COUNT;
      end
      SEQ_COUNT: begin
        if (!locked_i) begin
          state_d = SEQ_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(LOCK_CYCLES - 2)) state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (!locked_i) begin
          state_d = SEQ_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SEQ_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Outputs follow the next state so they are registered alongside it.
    rst_d   = (state_d != SEQ_RUN);
    ready_d = (state_d == SEQ_RUN);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= SEQ_WAIT_LOCK;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign rst_o   = rst_q;
  assign ready_o = ready_q;

endmodule
`default_nettype wire

// File: rtl/dac_out_fmt.sv
`default_nettype none
// ============================================================================
// Module      : dac_out_fmt
// Description : Parametrised DAC output formatter. Holds NB_CH samples with
//               per-channel load and force-idle, maps them to the DAC pins
//               (optional channel reversal / bit inversion), sequences the
//               DAC reset on PLL lock and flags channels not reloaded within
//               HOLD_TIMEOUT cycles.
// Config      : `define DAC_TEST_PATTERN_EN adds tp_en_i and a ramp test
//               pattern generator that overrides the sample loads.
// Ports       : dac_clk_i, dac_rstn_i  - clock, async active-low reset
//               dac_locked_i           - PLL lock
//               dac_dat_i              - samples, ch k at [k*DATA_WIDTH +:]
//               dac_dat_en_i           - per-channel load strobe
//               dac_dat_rst_i          - per-channel force idle
//               stale_clr_i            - clear all stale flags
//               tp_en_i                - test pattern enable (optional)
//               dac_dat_o              - formatted DAC words
//               dac_rst_o, dac_ready_o - DAC reset / sequencer in RUN
//               dac_stale_o            - sticky per-channel stale flags
// Revision    : 1.0 - initial release
// ============================================================================
module dac_out_fmt
  import dac_out_fmt_pkg::*;
#(
  parameter int NB_CH        = 2,
  parameter int DATA_WIDTH   = 14,
  parameter int INVERT_OUT   = 1,
  parameter int CH_REVERSE   = 1,
  parameter int LOCK_CYCLES  = 256,
  parameter int HOLD_TIMEOUT = 0
) (
  input  logic                        dac_clk_i,
  input  logic                        dac_rstn_i,
  input  logic                        dac_locked_i,
  input  logic [NB_CH*DATA_WIDTH-1:0] dac_dat_i,
  input  logic [NB_CH-1:0]            dac_dat_en_i,
  input  logic [NB_CH-1:0]            dac_dat_rst_i,
  input  logic                        stale_clr_i,
`ifdef DAC_TEST_PATTERN_EN
  input  logic                        tp_en_i,
`endif
  output logic [NB_CH*DATA_WIDTH-1:0] dac_dat_o,
  output logic                        dac_rst_o,
  output logic                        dac_ready_o,
  output logic [NB_CH-1:0]            dac_stale_o
);

  localparam logic [DATA_WIDTH-1:0] HOLD_IDLE = {DATA_WIDTH{HOLD_IDLE_BIT}};
  localparam logic [DATA_WIDTH-1:0] IDLE_CODE =
    (INVERT_OUT != 0) ? ~HOLD_IDLE : HOLD_IDLE;

  logic run;
  logic seq_rst;

  dac_lock_seq #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_seq (
    .clk_i    (dac_clk_i),
    .rstn_i   (dac_rstn_i),
    .locked_i (dac_locked_i),
    .rst_o    (seq_rst),
    .ready_o  (run)
  );

  assign dac_rst_o   = seq_rst;
  assign dac_ready_o = run;

`ifdef DAC_TEST_PATTERN_EN
  logic                  tp_active;
  logic [DATA_WIDTH-1:0] ramp_q, ramp_d;

  assign tp_active = tp_en_i & run;
  assign ramp_d    = run ? ramp_q + 1'b1 : ramp_q;

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) ramp_q <= '0;
    else             ramp_q <= ramp_d;
  end
`endif

  logic [DATA_WIDTH-1:0]       hold_q [NB_CH];
  logic [DATA_WIDTH-1:0]       hold_d [NB_CH];
  logic [NB_CH*DATA_WIDTH-1:0] out_q, out_d;

  // Force-idle (explicit or sequencer not in RUN) beats any load.
  always_comb begin
    for (int k = 0; k < NB_CH; k++) begin
      hold_d[k] = hold_q[k];
      if (dac_dat_rst_i[k] || !run) begin
        hold_d[k] = HOLD_IDLE;
      end
`ifdef DAC_TEST_PATTERN_EN
      else if (tp_active) begin
        hold_d[k] = ramp_q + DATA_WIDTH'(k);
      end
`endif
      else if (dac_dat_en_i[k]) begin
        hold_d[k] = dac_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    out_d = '0;
    for (int k = 0; k < NB_CH; k++) begin
      if (INVERT_OUT != 0) begin
        out_d[k*DATA_WIDTH +: DATA_WIDTH] =
          ~hold_q[(CH_REVERSE != 0) ? (NB_CH - 1 - k) : k];
      end else begin
        out_d[k*DATA_WIDTH +: DATA_WIDTH] =
          hold_q[(CH_REVERSE != 0) ? (NB_CH - 1 - k) : k];
      end
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      for (int k = 0; k < NB_CH; k++) hold_q[k] <= HOLD_IDLE;
      out_q <= {NB_CH{IDLE_CODE}};
    end else begin
      for (int k = 0; k < NB_CH; k++) hold_q[k] <= hold_d[k];
      out_q <= out_d;
    end
  end

  assign dac_dat_o = out_q;

  generate
    if (HOLD_TIMEOUT > 0) begin : g_stale
      localparam int SCNT_W = clog2(HOLD_TIMEOUT + 1);

      logic [NB_CH-1:0]  load;
      logic [SCNT_W-1:0] scnt_q [NB_CH];
      logic [SCNT_W-1:0] scnt_d [NB_CH];
      logic [NB_CH-1:0]  stale_q, stale_d;

`ifdef DAC_TEST_PATTERN_EN
      assign load = dac_dat_en_i | {NB_CH{tp_active}};
`else
      assign load = dac_dat_en_i;
`endif

      // The flag is set only on the cycle the counter reaches the timeout,
      // so a clear after saturation sticks until the channel re-expires.
      always_comb begin
        stale_d = stale_q & ~{NB_CH{stale_clr_i}};
        for (int k = 0; k < NB_CH; k++) begin
          scnt_d[k] = scnt_q[k];
          if (!run || load[k] || dac_dat_rst_i[k]) begin
            scnt_d[k] = '0;
          end else if (scnt_q[k] != SCNT_W'(HOLD_TIMEOUT)) begin
            scnt_d[k] = scnt_q[k] + 1'b1;
            if (scnt_q[k] == SCNT_W'(HOLD_TIMEOUT - 1)) stale_d[k] = 1'b1;
          end
        end
      end

      always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
          for (int k = 0; k < NB_CH; k++) scnt_q[k] <= '0;
          stale_q <= '0;
        end else begin
          for (int k = 0; k < NB_CH; k++) scnt_q[k] <= scnt_d[k];
          stale_q <= stale_d;
        end
      end

      assign dac_stale_o = stale_q;
    end else begin : g_no_stale
      logic unused_stale_clr;
      assign unused_stale_clr = stale_clr_i;
      assign dac_stale_o      = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dac_out_fmt.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_out_fmt
// Description : Scoreboard testbench for dac_out_fmt. A driver issues
//               directed and random stimulus, advances a behavioural model
//               one clock per stimulus and queues the expected outputs; a
//               monitor pops and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_out_fmt;

  localparam int NB_CH = 2;
  localparam int DW    = 14;
  localparam int INV   = 1;
  localparam int REV   = 1;
  localparam int LOCKC = 4;
  localparam int TO    = 8;

  typedef struct {
    logic [NB_CH*DW-1:0] dat;
    logic                rst;
    logic                ready;
    logic [NB_CH-1:0]    stale;
  } exp_t;

  logic                dac_clk_i;
  logic                dac_rstn_i;
  logic                dac_locked_i;
  logic [NB_CH*DW-1:0] dac_dat_i;
  logic [NB_CH-1:0]    dac_dat_en_i;
  logic [NB_CH-1:0]    dac_dat_rst_i;
  logic                stale_clr_i;
`ifdef DAC_TEST_PATTERN_EN
  logic                tp_en_i;
`endif
  logic [NB_CH*DW-1:0] dac_dat_o;
  logic                dac_rst_o;
  logic                dac_ready_o;
  logic [NB_CH-1:0]    dac_stale_o;

  dac_out_fmt #(
    .NB_CH        (NB_CH),
    .DATA_WIDTH   (DW),
    .INVERT_OUT   (INV),
    .CH_REVERSE   (REV),
    .LOCK_CYCLES  (LOCKC),
    .HOLD_TIMEOUT (TO)
  ) dut (
    .dac_clk_i     (dac_clk_i),
    .dac_rstn_i    (dac_rstn_i),
    .dac_locked_i  (dac_locked_i),
    .dac_dat_i     (dac_dat_i),
    .dac_dat_en_i  (dac_dat_en_i),
    .dac_dat_rst_i (dac_dat_rst_i),
    .stale_clr_i   (stale_clr_i),
`ifdef DAC_TEST_PATTERN_EN
    .tp_en_i       (tp_en_i),
`endif
    .dac_dat_o     (dac_dat_o),
    .dac_rst_o     (dac_rst_o),
    .dac_ready_o   (dac_ready_o),
    .dac_stale_o   (dac_stale_o)
  );

  initial dac_clk_i = 1'b0;
  always #5 dac_clk_i = ~dac_clk_i;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  // Reference model state: lock streak length, held samples, pin words,
  // per-channel idle-cycle counts, stale flags and test ramp.
  int              streak;
  logic [DW-1:0]   hold_m [NB_CH];
  logic [DW-1:0]   out_m  [NB_CH];
  int              idle_m [NB_CH];
  logic [NB_CH-1:0] stale_m;
  logic [DW-1:0]   ramp_m;
  logic [DW-1:0]   idle_code;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    streak  = 0;
    stale_m = '0;
    ramp_m  = '0;
    for (int k = 0; k < NB_CH; k++) begin
      hold_m[k] = '0;
      out_m[k]  = idle_code;
      idle_m[k] = 0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dat"},   64'(dac_dat_o),   64'({NB_CH{idle_code}}));
    check({tag, "_rst"},   64'(dac_rst_o),   64'd1);
    check({tag, "_ready"}, 64'(dac_ready_o), 64'd0);
    check({tag, "_stale"}, 64'(dac_stale_o), 64'd0);
  endtask

  // Apply one cycle of stimulus, step the model across the next rising edge
  // and queue what the DUT should show after that edge.
  task automatic drive_cycle(input logic lk, input logic [NB_CH*DW-1:0] dat,
                             input logic [NB_CH-1:0] en, input logic [NB_CH-1:0] rs,
                             input logic clr, input logic tp);
    logic run_prev;
    logic set;
    exp_t e;
    dac_locked_i  = lk;
    dac_dat_i     = dat;
    dac_dat_en_i  = en;
    dac_dat_rst_i = rs;
    stale_clr_i   = clr;
`ifdef DAC_TEST_PATTERN_EN
    tp_en_i       = tp;
`else
    if (tp) run_prev = 1'b0;
`endif
    run_prev = (streak >= LOCKC);
    for (int k = 0; k < NB_CH; k++) begin
      logic [DW-1:0] src;
      src = hold_m[(REV != 0) ? NB_CH - 1 - k : k];
      out_m[k] = (INV != 0) ? ~src : src;
    end
    for (int k = 0; k < NB_CH; k++) begin
      logic tp_load;
`ifdef DAC_TEST_PATTERN_EN
      tp_load = tp && run_prev;
`else
      tp_load = 1'b0;
`endif
      if (rs[k] || !run_prev)  hold_m[k] = '0;
      else if (tp_load)        hold_m[k] = DW'(ramp_m + k);
      else if (en[k])          hold_m[k] = dat[k*DW +: DW];
      set = 1'b0;
      if (!run_prev || en[k] || tp_load || rs[k]) idle_m[k] = 0;
      else if (idle_m[k] < TO) begin
        idle_m[k]++;
        set = (idle_m[k] == TO);
      end
      stale_m[k] = (stale_m[k] && !clr) || set;
    end
    if (run_prev) ramp_m = ramp_m + 1'b1;
    streak = lk ? ((streak < LOCKC) ? streak + 1 : streak) : 0;
    for (int k = 0; k < NB_CH; k++) e.dat[k*DW +: DW] = out_m[k];
    e.rst   = (streak < LOCKC);
    e.ready = (streak >= LOCKC);
    e.stale = stale_m;
    sb.push_back(e);
    @(negedge dac_clk_i);
  endtask

  task automatic async_reset();
    #2 dac_rstn_i = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    #1 dac_rstn_i = 1'b1;
  endtask

  // Monitor: compare after every rising edge for which a result is queued.
  always @(posedge dac_clk_i) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("dat_o",   64'(dac_dat_o),   64'(e.dat));
      check("rst_o",   64'(dac_rst_o),   64'(e.rst));
      check("ready_o", 64'(dac_ready_o), 64'(e.ready));
      check("stale_o", 64'(dac_stale_o), 64'(e.stale));
    end
  end

  function automatic logic [NB_CH*DW-1:0] rand_dat();
    logic [NB_CH*DW-1:0] d;
    for (int k = 0; k < NB_CH; k++) d[k*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  initial begin
    idle_code     = (INV != 0) ? '1 : '0;
    dac_rstn_i    = 1'b0;
    dac_locked_i  = 1'b0;
    dac_dat_i     = '0;
    dac_dat_en_i  = '0;
    dac_dat_rst_i = '0;
    stale_clr_i   = 1'b0;
`ifdef DAC_TEST_PATTERN_EN
    tp_en_i       = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge dac_clk_i);
    check_reset_values("reset");
    dac_rstn_i = 1'b1;

    // Lock drops while counting (cnt=2), then a full lock to RUN.
    repeat (3) drive_cycle(1'b1, '0, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (6) drive_cycle(1'b1, '0, '0, '0, 1'b0, 1'b0);

    // Two-channel load, then load+force-idle collision on ch0.
    drive_cycle(1'b1, {DW'(14'h1FFE), DW'(14'h0001)}, 2'b11, 2'b00, 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b1, '0, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, {DW'(14'h0555), DW'(14'h1234)}, 2'b01, 2'b01, 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b1, '0, 2'b01, '0, 1'b0, 1'b0);

    // ch1 starves until stale, clear, then a clear coincident with re-expiry.
    repeat (10) drive_cycle(1'b1, rand_dat(), 2'b01, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, rand_dat(), 2'b01, '0, 1'b1, 1'b0);
    drive_cycle(1'b1, rand_dat(), 2'b11, '0, 1'b0, 1'b0);
    repeat (7) drive_cycle(1'b1, rand_dat(), 2'b01, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, rand_dat(), 2'b01, '0, 1'b1, 1'b0);
    repeat (2) drive_cycle(1'b1, rand_dat(), 2'b01, '0, 1'b0, 1'b0);

    // Lock loss in RUN forces idle codes; then relock.
    repeat (3) drive_cycle(1'b0, rand_dat(), 2'b11, '0, 1'b0, 1'b0);
    repeat (6) drive_cycle(1'b1, rand_dat(), 2'b11, '0, 1'b0, 1'b0);

    // Random traffic with occasional lock drops and async resets.
    for (int i = 0; i < 3000; i++) begin
      logic [NB_CH-1:0] rs;
      for (int k = 0; k < NB_CH; k++) rs[k] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      drive_cycle(($urandom_range(0, 63) != 0), rand_dat(),
                  NB_CH'($urandom) & NB_CH'($urandom), rs,
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(negedge dac_clk_i);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
